// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one BCD digit per clock, least-significant digit first, with a start/busy/done handshake.
// Define BCD_SUB_EN to add the `sub` port for ten's-complement subtraction (a - b).
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  c_in,
`ifdef BCD_SUB_EN
   input  logic                  sub,
`endif
   output logic [4*DIGITS-1:0]   s,
   output logic                  c_out,
   output logic                  busy,
   output logic                  done,
   output logic                  invalid
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [4*DIGITS-1:0]  a_q, a_d;
   logic [4*DIGITS-1:0]  b_q, b_d;
   logic [4*DIGITS-1:0]  s_q, s_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 carry_q, carry_d;
   logic                 c_out_q, c_out_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 invalid_q, invalid_d;
`ifdef BCD_SUB_EN
   logic                 sub_q, sub_d;
`endif

   logic [3:0]           dig_a;
   logic [3:0]           dig_b;
   logic [3:0]           dig_b_eff;
   logic [4:0]           dig_sum;

   // Single-digit add with decimal adjust: {carry, digit}. Digits >9 still follow the same rule.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y,
                                                input logic cin);
      logic [4:0] raw;
      raw = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
      if (raw > 5'd9)
         return {1'b1, raw[3:0] + 4'd6};
      return {1'b0, raw[3:0]};
   endfunction

   function automatic logic digit_bad(input logic [3:0] d);
      return (d > 4'd9);
   endfunction

   always_comb begin
      dig_a = 4'd0;
      dig_b = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            dig_a = a_q[4*k +: 4];
            dig_b = b_q[4*k +: 4];
         end
      end
`ifdef BCD_SUB_EN
      dig_b_eff = sub_q ? (4'd9 - dig_b) : dig_b;
`else
      dig_b_eff = dig_b;
`endif
      dig_sum = bcd_digit_add(dig_a, dig_b_eff, carry_q);
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      s_d       = s_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      c_out_d   = c_out_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      invalid_d = invalid_q;
`ifdef BCD_SUB_EN
      sub_d     = sub_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d       = a;
               b_d       = b;
`ifdef BCD_SUB_EN
               sub_d     = sub;
               carry_d   = sub ? 1'b1 : c_in;
`else
               carry_d   = c_in;
`endif
               s_d       = '0;
               c_out_d   = 1'b0;
               invalid_d = 1'b0;
               idx_d     = '0;
               busy_d    = 1'b1;
               state_d   = ADD;
            end
         end

         ADD: begin
            for (int k = 0; k < DIGITS; k++) begin
               if (idx_q == IDX_W'(k))
                  s_d[4*k +: 4] = dig_sum[3:0];
            end
            carry_d = dig_sum[4];
            // Validity is judged on the operands as supplied, before any complementing.
            if (digit_bad(dig_a) || digit_bad(dig_b))
               invalid_d = 1'b1;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
               c_out_d = dig_sum[4];
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         s_q       <= '0;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         c_out_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         invalid_q <= 1'b0;
`ifdef BCD_SUB_EN
         sub_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         s_q       <= s_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         c_out_q   <= c_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         invalid_q <= invalid_d;
`ifdef BCD_SUB_EN
         sub_q     <= sub_d;
`endif
      end
   end

   assign s       = s_q;
   assign c_out   = c_out_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4); subtraction vectors run when BCD_SUB_EN is defined.
module tb_bcd_serial_adder;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic          clk;
   logic          rst_n;
   logic          start_r;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic          cin_r;
`ifdef BCD_SUB_EN
   logic          sub_r;
`endif
   logic [W-1:0]  s;
   logic          c_out;
   logic          busy;
   logic          done;
   logic          invalid;

   int tests_run;
   int tests_failed;

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_r),
      .a       (a_r),
      .b       (b_r),
      .c_in    (cin_r),
`ifdef BCD_SUB_EN
      .sub     (sub_r),
`endif
      .s       (s),
      .c_out   (c_out),
      .busy    (busy),
      .done    (done),
      .invalid (invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits for the done pulse; cyc counts rising edges seen. Gives up after 30 edges.
   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) return;
      end
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] exp_s, input logic exp_c,
                        input logic exp_inv);
      int cyc;
      @(negedge clk);
      a_r     = av;
      b_r     = bv;
      cin_r   = cv;
      start_r = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      start_r = 1'b0;
      a_r     = W'($urandom);
      b_r     = W'($urandom);
      cin_r   = ~cv;
      wait_done(cyc);
      chk({tag, "_lat"}, 32'(cyc), 32'(DIGITS + 1));
      chk({tag, "_s"}, 32'(s), 32'(exp_s));
      chk({tag, "_cout"}, 32'(c_out), 32'(exp_c));
      chk({tag, "_inv"}, 32'(invalid), 32'(exp_inv));
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_s_hold"}, 32'(s), 32'(exp_s));
   endtask

   initial begin
      int cyc;
      int ndone;
      logic [W-1:0] s_at_done;
      tests_run    = 0;
      tests_failed = 0;
      rst_n   = 1'b0;
      start_r = 1'b0;
      a_r     = '0;
      b_r     = '0;
      cin_r   = 1'b0;
`ifdef BCD_SUB_EN
      sub_r   = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_cout", 32'(c_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_inv", 32'(invalid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("basic", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
      do_op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op("cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
      do_op("bad_digit", 16'h00A5, 16'h0003, 1'b0, 16'h0108, 1'b0, 1'b1);
      do_op("inv_clear", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
      do_op("max", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

      // Second start two cycles in must be ignored; also observe partial sum.
      @(negedge clk);
      a_r     = 16'h1234;
      b_r     = 16'h5678;
      cin_r   = 1'b0;
      start_r = 1'b1;
      @(posedge clk);
      #1;
      start_r = 1'b0;
      @(posedge clk);
      #1;
      chk("partial_d0", 32'(s), 32'h0002);
      @(posedge clk);
      #1;
      chk("partial_d1", 32'(s), 32'h0012);
      a_r     = 16'h1111;
      b_r     = 16'h1111;
      start_r = 1'b1;
      @(posedge clk);
      #1;
      start_r = 1'b0;
      ndone     = 0;
      s_at_done = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            s_at_done = s;
         end
      end
      chk("ignore_ndone", 32'(ndone), 32'd1);
      chk("ignore_s", 32'(s_at_done), 32'h6912);

      // Reset asserted during the third ADD cycle.
      @(negedge clk);
      a_r     = 16'h4444;
      b_r     = 16'h4444;
      start_r = 1'b1;
      @(posedge clk);
      #1;
      start_r = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_s", 32'(s), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("midrst_nodone", 32'(ndone), 32'd0);
      do_op("after_rst", 16'h0505, 16'h0505, 1'b0, 16'h1010, 1'b0, 1'b0);

      // Start held high: back-to-back operations separated by one IDLE cycle.
      @(negedge clk);
      a_r     = 16'h1000;
      b_r     = 16'h2000;
      cin_r   = 1'b0;
      start_r = 1'b1;
      @(posedge clk);
      #1;
      wait_done(cyc);
      chk("b2b_lat", 32'(cyc), 32'(DIGITS + 1));
      chk("b2b_s1", 32'(s), 32'h3000);
      a_r = 16'h2222;
      b_r = 16'h3333;
      @(posedge clk);
      #1;
      chk("b2b_restart", 32'(busy), 32'd1);
      start_r = 1'b0;
      wait_done(cyc);
      chk("b2b_lat2", 32'(cyc), 32'(DIGITS + 1));
      chk("b2b_s2", 32'(s), 32'h5555);

`ifdef BCD_SUB_EN
      sub_r = 1'b1;
      do_op("sub_nb", 16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b1, 1'b0);
      do_op("sub_borrow", 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0);
      sub_r = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Digit-serial multi-digit BCD adder. It sits directly downstream of the single-digit BCD add/adjust datapath: fulladd4 produces the raw sum, compare against 9 decides the correction, and mux2to1_nbits selects +6 or +0.
This block sequences that per-digit operation over DIGITS BCD digits, one digit per clock, least-significant digit first. It holds a carry register between digits and presents the full result with a start/busy/done handshake.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal range 1..16).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; asynchronous assert, active-low
start  input  1  request a new operation; sampled only in IDLE
a  input  4*DIGITS  operand A, packed BCD, digit 0 at [3:0]
b  input  4*DIGITS  operand B, packed BCD
c_in  input  1  carry into digit 0
s  output  4*DIGITS  packed BCD sum
c_out  output  1  carry out of the most significant digit
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when s/c_out are valid
invalid  output  1  an operand digit was >9 during the last operation

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; s=0, c_out=0, busy=0, done=0, invalid=0; carry register=0; digit index=0; operand registers=0.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - On start=1, capture a, b and c_in into internal registers.
  - Clear s, c_out and invalid; set index=0.
  - Go to ADD. busy is 1 from the next cycle.
- ADD, one digit per cycle, at index i:
  - raw = a_i + b_i + carry (5-bit).
  - If raw > 9: digit = (raw + 6)[3:0], carry = 1.
  - Otherwise: digit = raw[3:0], carry = 0.
  - Write digit into s[4i+3:4i].
  - If a_i > 9 or b_i > 9, set invalid (sticky for this operation). The same computation rule still applies.
  - If i == DIGITS-1: c_out = carry and go to DONE. Otherwise i = i+1.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE.
- Latency: start sampled at edge 0 -> done high after edge DIGITS+1 (DIGITS ADD cycles plus the DONE cycle).
- Results: s, c_out and invalid hold their values after done until the next accepted start.
- start outside IDLE (ADD or DONE) is ignored: no queueing, no restart.
- start held high continuously gives back-to-back operations with one IDLE cycle between them.
- Input change: a, b and c_in may change after capture without affecting the operation in flight.
- Reset mid-operation: immediate return to reset values. No done pulse is produced.
- Intermediate visibility: s digits above the current index read 0 during ADD.

Optional Feature:
- Macro: BCD_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled together with start.
  - When sub=1, each b digit is replaced by its nine's complement (9 - b_i) and the initial carry is forced to 1, ignoring c_in. The result is a - b in ten's complement.
  - c_out=1 means no borrow (a >= b); c_out=0 means a borrow occurred.
  - invalid checks the original b digits.
- When undefined:
  - The sub port does not exist; the block is addition only.

Test Plan:
- DIGITS=4, a=0x1234, b=0x5678, c_in=0, pulse start -> done exactly 5 cycles after start; s=0x6912, c_out=0, invalid=0.
- a=0x9999, b=0x0001, c_in=0 -> s=0x0000, c_out=1 (carry ripples through all digits). Also a=0x0000, b=0x0000, c_in=1 -> s=0x0001, c_out=0.
- a=0x00A5, b=0x0003, c_in=0 -> invalid=1 after done; s=0x0108 per the adjust rule. A following valid operation clears invalid.
- Pulse start again 2 cycles into an operation with different operands -> ignored. The result matches the first operands; exactly one done pulse.
- Assert rst_n=0 in the third ADD cycle -> s=0, busy=0, done never pulses. A fresh start afterwards completes normally.
- With BCD_SUB_EN: a=0x5000, b=0x1234, sub=1 -> s=0x3766, c_out=1. Then a=0x0001, b=0x0002, sub=1 -> s=0x9999, c_out=0.
